// File: rtl/bcd_countdown_timer.sv
// Six-digit BCD countdown timer (MM:SS.hh). Loads a sanitised preset, counts
// down one hundredth per tick while running, and flags expiry at 00:00.00.
module bcd_countdown_timer (
    input  logic        clk,
    input  logic        rst,
    input  logic        tick,
    input  logic        load,
    input  logic [23:0] load_val,
    input  logic        start,
    input  logic        stop,
    output logic [23:0] digits,
    output logic        running,
    output logic        done,
    output logic        expired
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RUN     = 2'd1,
        PAUSED  = 2'd2,
        EXPIRED = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [23:0] digits_q, digits_d;
    logic        done_q, done_d;
    logic        running_q, running_d;
    logic        expired_q, expired_d;

    logic [23:0] load_clean;
    logic [23:0] dec_val;
    logic [6:0]  borrow;

    assign borrow[0] = 1'b1;

    // Digit 3 is seconds-tens, the only digit whose range stops at 5.
    generate
        for (genvar gi = 0; gi < 6; gi++) begin : g_digit
            localparam logic [3:0] DMAX = (gi == 3) ? 4'd5 : 4'd9;
            logic [3:0] cur;
            logic [3:0] raw;

            assign cur = digits_q[gi*4 +: 4];
            assign raw = load_val[gi*4 +: 4];

            assign load_clean[gi*4 +: 4] = (raw > DMAX) ? DMAX : raw;

            assign dec_val[gi*4 +: 4] = !borrow[gi]    ? cur  :
                                        (cur == 4'd0)  ? DMAX : cur - 4'd1;
            assign borrow[gi+1] = borrow[gi] && (cur == 4'd0);
        end
    endgenerate

    always_comb begin
        state_d  = state_q;
        digits_d = digits_q;
        done_d   = 1'b0;

        if (load) begin
            digits_d = load_clean;
            state_d  = IDLE;
        end else if (stop && state_q == RUN) begin
            state_d = PAUSED;
        end else if (stop) begin
            state_d = state_q;
        end else if (start && (state_q == IDLE || state_q == PAUSED)) begin
            if (digits_q != 24'd0) begin
                state_d = RUN;
            end
        end else if (tick && state_q == RUN) begin
            digits_d = dec_val;
            if (dec_val == 24'd0) begin
                state_d = EXPIRED;
                done_d  = 1'b1;
            end
        end

        running_d = (state_d == RUN);
        expired_d = (state_d == EXPIRED);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            digits_q  <= 24'd0;
            done_q    <= 1'b0;
            running_q <= 1'b0;
            expired_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            digits_q  <= digits_d;
            done_q    <= done_d;
            running_q <= running_d;
            expired_q <= expired_d;
        end
    end

    assign digits  = digits_q;
    assign running = running_q;
    assign done    = done_q;
    assign expired = expired_q;

endmodule

// File: tb/tb_bcd_countdown_timer.sv
// Scoreboard bench for bcd_countdown_timer: stimulus queues expected outputs
// tagged with the cycle they must appear in; a monitor compares on negedge.
module tb_bcd_countdown_timer;

    logic        clk;
    logic        rst;
    logic        tick;
    logic        load;
    logic [23:0] load_val;
    logic        start;
    logic        stop;
    logic [23:0] digits;
    logic        running;
    logic        done;
    logic        expired;

    typedef struct {
        int unsigned cyc;
        logic [23:0] dig;
        logic        run;
        logic        dn;
        logic        exp;
        string       name;
    } exp_t;

    exp_t        sb[$];
    int unsigned cycle_cnt = 0;
    int          tests_run = 0;
    int          tests_failed = 0;

    bcd_countdown_timer dut (
        .clk      (clk),
        .rst      (rst),
        .tick     (tick),
        .load     (load),
        .load_val (load_val),
        .start    (start),
        .stop     (stop),
        .digits   (digits),
        .running  (running),
        .done     (done),
        .expired  (expired)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cycle_cnt = cycle_cnt + 1;

    // Monitor: every entry due in the current cycle is popped and compared.
    always @(negedge clk) begin
        while (sb.size() > 0 && sb[0].cyc <= cycle_cnt) begin
            exp_t e;
            e = sb.pop_front();
            tests_run++;
            if (e.cyc != cycle_cnt || digits !== e.dig || running !== e.run ||
                done !== e.dn || expired !== e.exp) begin
                tests_failed++;
                $display("[TB] FAIL %s: got digits=%h run=%b done=%b exp=%b, expected digits=%h run=%b done=%b exp=%b",
                         e.name, digits, running, done, expired, e.dig, e.run, e.dn, e.exp);
            end else begin
                $display("[TB] ok %s: digits=%h run=%b done=%b exp=%b",
                         e.name, digits, running, done, expired);
            end
        end
    end

    // One clock of stimulus; optional expectation for the outputs after the edge.
    task automatic step(input bit r, input bit l, input bit st, input bit sp,
                        input bit tk, input logic [23:0] lv, input string nm,
                        input bit chk, input logic [23:0] ed, input bit er,
                        input bit edn, input bit eex);
        exp_t e;
        @(posedge clk);
        #1;
        rst = r; load = l; start = st; stop = sp; tick = tk; load_val = lv;
        if (chk) begin
            e.cyc  = cycle_cnt + 1;
            e.dig  = ed;
            e.run  = er;
            e.dn   = edn;
            e.exp  = eex;
            e.name = nm;
            sb.push_back(e);
        end
    endtask

    task automatic hold(input int n, input string nm, input logic [23:0] ed,
                        input bit er, input bit eex);
        for (int i = 0; i < n; i++)
            step(0, 0, 0, 0, 0, 24'h0, nm, 1, ed, er, 0, eex);
    endtask

    logic [23:0] t3_vals [10] = '{24'h052999, 24'h052998, 24'h052997, 24'h052996,
                                  24'h052995, 24'h052994, 24'h052993, 24'h052992,
                                  24'h052991, 24'h052990};

    initial begin
        rst = 1'b1; load = 1'b0; start = 1'b0; stop = 1'b0; tick = 1'b0;
        load_val = 24'h0;

        // Test 1: basic countdown to zero with done pulse
        step(1, 0, 0, 0, 0, 24'h0,      "t1_reset", 1, 24'h000000, 0, 0, 0);
        step(0, 1, 0, 0, 0, 24'h000003, "t1_load",  1, 24'h000003, 0, 0, 0);
        step(0, 0, 1, 0, 1, 24'h0,      "t1_start_tick_ignored", 1, 24'h000003, 1, 0, 0);
        hold(4, "t1_wait0", 24'h000003, 1, 0);
        step(0, 0, 0, 0, 1, 24'h0,      "t1_tick1", 1, 24'h000002, 1, 0, 0);
        hold(4, "t1_wait1", 24'h000002, 1, 0);
        step(0, 0, 0, 0, 1, 24'h0,      "t1_tick2", 1, 24'h000001, 1, 0, 0);
        hold(4, "t1_wait2", 24'h000001, 1, 0);
        step(0, 0, 0, 0, 1, 24'h0,      "t1_tick3_done", 1, 24'h000000, 0, 1, 1);
        hold(3, "t1_expired_hold", 24'h000000, 0, 1);
        step(0, 0, 1, 0, 0, 24'h0,      "t1_start_in_expired", 1, 24'h000000, 0, 0, 1);
        step(0, 0, 0, 0, 1, 24'h0,      "t1_tick_in_expired", 1, 24'h000000, 0, 0, 1);
        step(0, 0, 1, 0, 1, 24'h0,      "t1_start_tick_expired", 1, 24'h000000, 0, 0, 1);

        // Test 2: full borrow chain
        step(0, 1, 0, 0, 0, 24'h100000, "t2_load", 1, 24'h100000, 0, 0, 0);
        step(0, 0, 1, 0, 0, 24'h0,      "t2_start", 1, 24'h100000, 1, 0, 0);
        step(0, 0, 0, 0, 1, 24'h0,      "t2_borrow", 1, 24'h095999, 1, 0, 0);

        // Test 3: run, pause with same-cycle tick, resume
        step(0, 1, 0, 0, 0, 24'h053000, "t3_load", 1, 24'h053000, 0, 0, 0);
        step(0, 0, 1, 0, 0, 24'h0,      "t3_start", 1, 24'h053000, 1, 0, 0);
        for (int i = 0; i < 10; i++)
            step(0, 0, 0, 0, 1, 24'h0, "t3_tick", 1, t3_vals[i], 1, 0, 0);
        step(0, 0, 0, 1, 1, 24'h0,      "t3_stop_tick", 1, 24'h052990, 0, 0, 0);
        for (int i = 0; i < 5; i++)
            step(0, 0, 0, 0, 1, 24'h0, "t3_paused_tick", 1, 24'h052990, 0, 0, 0);
        step(0, 0, 1, 0, 0, 24'h0,      "t3_resume", 1, 24'h052990, 1, 0, 0);
        step(0, 0, 0, 0, 1, 24'h0,      "t3_resume_tick", 1, 24'h052989, 1, 0, 0);

        // Test 4: sanitising the preset
        step(0, 1, 0, 0, 0, 24'hFA7BC9, "t4_sanitise", 1, 24'h995999, 0, 0, 0);

        // Test 5: start on zero, start+stop together
        step(0, 1, 0, 0, 0, 24'h000000, "t5_load_zero", 1, 24'h000000, 0, 0, 0);
        step(0, 0, 1, 0, 0, 24'h0,      "t5_start_zero", 1, 24'h000000, 0, 0, 0);
        step(0, 1, 0, 0, 0, 24'h000100, "t5_load", 1, 24'h000100, 0, 0, 0);
        step(0, 0, 1, 1, 0, 24'h0,      "t5_start_stop", 1, 24'h000100, 0, 0, 0);
        step(0, 0, 0, 0, 1, 24'h0,      "t5_tick_idle", 1, 24'h000100, 0, 0, 0);

        // Test 6: reset and load override the zero-reaching tick
        step(0, 1, 0, 0, 0, 24'h000001, "t6_load", 1, 24'h000001, 0, 0, 0);
        step(0, 0, 1, 0, 0, 24'h0,      "t6_start", 1, 24'h000001, 1, 0, 0);
        step(1, 0, 0, 0, 1, 24'h0,      "t6_rst_tick", 1, 24'h000000, 0, 0, 0);
        step(0, 0, 0, 0, 0, 24'h0,      "t6_after_rst", 1, 24'h000000, 0, 0, 0);
        step(0, 1, 0, 0, 0, 24'h000002, "t6_load2", 1, 24'h000002, 0, 0, 0);
        step(0, 0, 1, 0, 0, 24'h0,      "t6_start2", 1, 24'h000002, 1, 0, 0);
        step(0, 0, 0, 0, 1, 24'h0,      "t6_tick", 1, 24'h000001, 1, 0, 0);
        step(0, 1, 0, 0, 1, 24'h000500, "t6_load_tick", 1, 24'h000500, 0, 0, 0);
        step(0, 0, 0, 0, 0, 24'h0,      "t6_after_load", 1, 24'h000500, 0, 0, 0);

        step(0, 0, 0, 0, 0, 24'h0, "drain", 0, 24'h0, 0, 0, 0);
        for (int i = 0; i < 20 && sb.size() > 0; i++) @(negedge clk);
        if (sb.size() > 0) begin
            tests_run++;
            tests_failed++;
            $display("[TB] FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
